// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   Oversampling UART receiver. Recovers frames of the form
//   start bit, DATA_BITS data bits (LSB first), optional parity bit, one stop bit.
//   Each good word is presented on Rx_Data together with a one-cycle Data_Rdy
//   strobe. Parity errors are flagged with that strobe, and framing errors are
//   flagged with their own strobe.
//
// Ports
//   Clk        in   system clock, all logic on posedge
//   Rst_n      in   asynchronous active-low reset
//   Baud_Tick  in   one-Clk enable pulse at OVERSAMPLE x baud rate
//   Rx_Serial  in   asynchronous serial line, idle high
//   Rx_Data    out  last good received word (held between strobes)
//   Data_Rdy   out  one-Clk pulse, Rx_Data updated this cycle
//   Parity_Err out  valid with Data_Rdy: parity mismatch on that word
//   Frame_Err  out  one-Clk pulse: stop bit sampled low
//   Rx_Busy    out  high whenever the receiver is not idle
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Baud_Tick,
  input  logic                 Rx_Serial,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Data_Rdy,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Rx_Busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t                 state, state_nx;
  logic                   sync1, sync2;
  logic [TW-1:0]          tick_cnt, tick_nx;
  logic [BW-1:0]          bit_cnt, bit_nx;
  logic [DATA_BITS-1:0]   shift, shift_nx;
  logic                   perr_hold, perr_hold_nx;
  logic [DATA_BITS-1:0]   data_nx;
  logic                   rdy_nx, perr_out_nx, ferr_nx;
  logic                   rx_s;

  // True when the received data plus parity bit violate the chosen parity.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic pbit);
    return (^d) ^ pbit ^ (PARITY_ODD != 0);
  endfunction

  assign rx_s = sync2;

  always_comb begin
    state_nx     = state;
    tick_nx      = tick_cnt;
    bit_nx       = bit_cnt;
    shift_nx     = shift;
    perr_hold_nx = perr_hold;
    data_nx      = Rx_Data;
    rdy_nx       = 1'b0;
    perr_out_nx  = 1'b0;
    ferr_nx      = 1'b0;

    if (Baud_Tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nx = START;
            tick_nx  = '0;
          end
        end

        // Re-check the line at the middle of the start bit; a high level
        // means the falling edge was a glitch.
        START: begin
          if (tick_cnt == TICK_MID) begin
            tick_nx = '0;
            if (rx_s) begin
              state_nx = IDLE;
            end else begin
              state_nx = DATA;
              bit_nx   = '0;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end

        // Counting from mid-start, every full bit period lands mid-bit.
        // Shifting in at the MSB leaves the first (LSB) bit at bit 0.
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nx  = '0;
            shift_nx = {rx_s, shift[DATA_BITS-1:1]};
            bit_nx   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state_nx = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nx      = '0;
            perr_hold_nx = parity_bad(shift, rx_s);
            state_nx     = STOP;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end

        // Returning to IDLE at mid-stop lets a back-to-back start bit be caught.
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nx = '0;
            if (rx_s) begin
              state_nx    = IDLE;
              data_nx     = shift;
              rdy_nx      = 1'b1;
              perr_out_nx = (PARITY_EN != 0) ? perr_hold : 1'b0;
            end else begin
              state_nx = BREAK;
              ferr_nx  = 1'b1;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end

        // Absorb a held-low line so it reports only one framing error.
        BREAK: begin
          if (rx_s) begin
            state_nx = IDLE;
          end
        end

        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      perr_hold  <= 1'b0;
      Rx_Data    <= '0;
      Data_Rdy   <= 1'b0;
      Parity_Err <= 1'b0;
      Frame_Err  <= 1'b0;
      Rx_Busy    <= 1'b0;
    end else begin
      sync1      <= Rx_Serial;
      sync2      <= sync1;
      state      <= state_nx;
      tick_cnt   <= tick_nx;
      bit_cnt    <= bit_nx;
      shift      <= shift_nx;
      perr_hold  <= perr_hold_nx;
      Rx_Data    <= data_nx;
      Data_Rdy   <= rdy_nx;
      Parity_Err <= perr_out_nx;
      Frame_Err  <= ferr_nx;
      Rx_Busy    <= (state_nx != IDLE);
    end
  end

endmodule
